scan_config_ctrl: RTL and testbench

- Configuration sequencer for one FPGA tile's two scan chains: the CLB chain and the connection chain (switch block, top connection block, right connection block).
- Accepts the bitstream as WORD_W-bit words over a valid/ready handshake and serialises it LSB-first, CLB chain first, then connection chain.
- Generates scan_clk and both scan enables. Captures the previous configuration shifted out of each chain as readback words.
- Sits between the chip-level configuration port and the tile's scan pins.

---
 rtl/scan_config_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_scan_config_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_config_ctrl.sv
// Configuration scan sequencer for one FPGA tile.
// Takes bitstream words over valid/ready, shifts them LSB-first into the CLB
// chain and then the connection chain, generates scan_clk and the chain
// enables, and returns the previous chain contents as readback words.
module scan_config_ctrl #(
    parameter int unsigned WORD_W         = 8,
    parameter int unsigned CLB_CHAIN_LEN  = 20,
    parameter int unsigned CONN_CHAIN_LEN = 48,
    parameter int unsigned SCAN_DIV       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              scan_clk,
    output logic              clb_scan_en,
    output logic              clb_scan_in,
    input  logic              clb_scan_out,
    output logic              conn_scan_en,
    output logic              conn_scan_in,
    input  logic              conn_scan_out,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int unsigned TOTAL = CLB_CHAIN_LEN + CONN_CHAIN_LEN;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned IDX_W = $clog2(WORD_W + 1);
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_FLUSH,
        S_FINISH
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [DIV_W-1:0]  r_div_cnt;
    logic [CNT_W-1:0]  r_bit_count;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_rb_acc;
    logic [IDX_W-1:0]  r_rb_cnt;
    logic [WORD_W-1:0] r_rb_data;
    logic              r_rb_valid;
    logic              r_scan_clk;
    logic              r_clb_en;
    logic              r_conn_en;
    logic              r_clb_in;
    logic              r_conn_in;

    logic              w_div_last;
    logic [CNT_W-1:0]  w_bit_count_inc;
    logic [IDX_W-1:0]  w_bit_idx_inc;
    logic              w_last_bit;
    logic              w_word_end;
    logic              w_accept;
    logic              w_lo_end;
    logic              w_hi_end;
    logic              w_enter_lo;
    logic [WORD_W-1:0] w_shift_nxt;
    logic              w_drive_bit;
    logic [CNT_W-1:0]  w_drive_pos;
    logic              w_drive_clb;
    logic              w_sample_bit;
    logic [WORD_W-1:0] w_rb_merged;
    logic              w_rb_full;

    assign w_div_last      = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
    assign w_bit_count_inc = r_bit_count + 1'b1;
    assign w_bit_idx_inc   = r_bit_idx + 1'b1;
    assign w_last_bit      = (w_bit_count_inc == CNT_W'(TOTAL));
    assign w_word_end      = (w_bit_idx_inc == IDX_W'(WORD_W));
    assign w_accept        = (r_state == S_FETCH) && cfg_valid;
    assign w_lo_end        = (r_state == S_SHIFT_LO) && w_div_last;
    assign w_hi_end        = (r_state == S_SHIFT_HI) && w_div_last;
    assign w_enter_lo      = (w_state_next == S_SHIFT_LO) && (r_state != S_SHIFT_LO);
    assign w_shift_nxt     = r_shift >> 1;

    // The next bit is registered onto the scan pins on entry to SHIFT_LO so it
    // is already stable during the first low cycle: from FETCH it is the new
    // word's LSB, from SHIFT_HI it is the following bit of the current word.
    assign w_drive_bit  = (r_state == S_FETCH) ? cfg_data[0] : w_shift_nxt[0];
    assign w_drive_pos  = (r_state == S_FETCH) ? r_bit_count : w_bit_count_inc;
    assign w_drive_clb  = (w_drive_pos < CNT_W'(CLB_CHAIN_LEN));

    assign w_sample_bit = r_clb_en ? clb_scan_out : conn_scan_out;
    assign w_rb_merged  = r_rb_acc | (WORD_W'(w_sample_bit) << r_rb_cnt);
    assign w_rb_full    = (IDX_W'(r_rb_cnt + 1'b1) == IDX_W'(WORD_W));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        cfg_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                busy      = 1'b1;
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_state_next = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                busy = 1'b1;
                if (w_div_last) begin
                    w_state_next = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                busy = 1'b1;
                if (w_div_last) begin
                    if (w_last_bit) begin
                        w_state_next = S_FLUSH;
                    end else if (w_word_end) begin
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_SHIFT_LO;
                    end
                end
            end
            S_FLUSH: begin
                busy         = 1'b1;
                w_state_next = S_FINISH;
            end
            S_FINISH: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Half-period divider, restarted on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_div_cnt <= '0;
        end else if ((r_state == S_SHIFT_LO) || (r_state == S_SHIFT_HI)) begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Word shift register, bit index within word and total bit count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_bit_count <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_bit_idx   <= '0;
            r_bit_count <= '0;
        end else if (w_accept) begin
            r_shift   <= cfg_data;
            r_bit_idx <= '0;
        end else if (w_hi_end) begin
            r_shift     <= w_shift_nxt;
            r_bit_idx   <= w_bit_idx_inc;
            r_bit_count <= w_bit_count_inc;
        end
    end

    // Scan pins: clock follows SHIFT_HI, enables/data update only as the clock falls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_clk <= 1'b0;
            r_clb_en   <= 1'b0;
            r_conn_en  <= 1'b0;
            r_clb_in   <= 1'b0;
            r_conn_in  <= 1'b0;
        end else begin
            r_scan_clk <= (w_state_next == S_SHIFT_HI);
            if (w_enter_lo) begin
                if (w_drive_clb) begin
                    r_clb_en  <= 1'b1;
                    r_conn_en <= 1'b0;
                    r_clb_in  <= w_drive_bit;
                end else begin
                    r_clb_en  <= 1'b0;
                    r_conn_en <= 1'b1;
                    r_conn_in <= w_drive_bit;
                end
            end else if (w_state_next == S_FLUSH) begin
                r_clb_en  <= 1'b0;
                r_conn_en <= 1'b0;
            end
        end
    end

    // Readback assembly: full words as they fill, trailing partial word on entry to FLUSH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rb_acc   <= '0;
            r_rb_cnt   <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if ((r_state == S_IDLE) && start) begin
                r_rb_acc <= '0;
                r_rb_cnt <= '0;
            end else if (w_lo_end) begin
                if (w_rb_full) begin
                    r_rb_data  <= w_rb_merged;
                    r_rb_valid <= 1'b1;
                    r_rb_acc   <= '0;
                    r_rb_cnt   <= '0;
                end else begin
                    r_rb_acc <= w_rb_merged;
                    r_rb_cnt <= r_rb_cnt + 1'b1;
                end
            end else if (w_hi_end && w_last_bit && (r_rb_cnt != '0)) begin
                r_rb_data  <= r_rb_acc;
                r_rb_valid <= 1'b1;
                r_rb_acc   <= '0;
                r_rb_cnt   <= '0;
            end
        end
    end

    assign scan_clk     = r_scan_clk;
    assign clb_scan_en  = r_clb_en;
    assign clb_scan_in  = r_clb_in;
    assign conn_scan_en = r_conn_en;
    assign conn_scan_in = r_conn_in;
    assign rb_data      = r_rb_data;
    assign rb_valid     = r_rb_valid;

endmodule

// File: tb/tb_scan_config_ctrl.sv
// Randomized bench for scan_config_ctrl with behavioural scan-chain models.
module tb_scan_config_ctrl;

    localparam int unsigned W      = 8;
    localparam int unsigned CLB    = 20;
    localparam int unsigned CONN   = 48;
    localparam int unsigned TOTAL  = CLB + CONN;
    localparam int unsigned NWORDS = (TOTAL + W - 1) / W;

    typedef logic [W-1:0] word_arr_t [NWORDS];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, cfg_valid;
    logic [W-1:0]  cfg_data;
    logic          busy, done, cfg_ready, scan_clk;
    logic          clb_scan_en, clb_scan_in, clb_scan_out;
    logic          conn_scan_en, conn_scan_in, conn_scan_out;
    logic [W-1:0]  rb_data;
    logic          rb_valid;

    logic          start1, cfg_valid1;
    logic [W-1:0]  cfg_data1;
    logic          busy1, done1, cfg_ready1, scan_clk1;
    logic          clb_scan_en1, clb_scan_in1, conn_scan_en1, conn_scan_in1;
    logic [W-1:0]  rb_data1;
    logic          rb_valid1;

    scan_config_ctrl #(.WORD_W(W), .CLB_CHAIN_LEN(CLB), .CONN_CHAIN_LEN(CONN), .SCAN_DIV(2)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .scan_clk(scan_clk),
        .clb_scan_en(clb_scan_en), .clb_scan_in(clb_scan_in), .clb_scan_out(clb_scan_out),
        .conn_scan_en(conn_scan_en), .conn_scan_in(conn_scan_in), .conn_scan_out(conn_scan_out),
        .rb_data(rb_data), .rb_valid(rb_valid)
    );

    scan_config_ctrl #(.WORD_W(W), .CLB_CHAIN_LEN(CLB), .CONN_CHAIN_LEN(CONN), .SCAN_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .cfg_data(cfg_data1), .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1),
        .scan_clk(scan_clk1),
        .clb_scan_en(clb_scan_en1), .clb_scan_in(clb_scan_in1), .clb_scan_out(1'b0),
        .conn_scan_en(conn_scan_en1), .conn_scan_in(conn_scan_in1), .conn_scan_out(1'b0),
        .rb_data(rb_data1), .rb_valid(rb_valid1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tile scan chain models: shift on scan_clk rise when enabled, out from the far end
    logic [CLB-1:0]  clb_chain, clb_pre, clb_rec;
    logic [CONN-1:0] conn_chain, conn_pre, conn_rec;
    int              clb_rises, conn_rises;
    logic            mon_clr = 1'b0;

    assign clb_scan_out  = clb_chain[CLB-1];
    assign conn_scan_out = conn_chain[CONN-1];

    always @(posedge scan_clk or posedge mon_clr) begin
        if (mon_clr) begin
            clb_chain  <= clb_pre;
            conn_chain <= conn_pre;
            clb_rec    <= '0;
            conn_rec   <= '0;
            clb_rises  <= 0;
            conn_rises <= 0;
        end else begin
            if (clb_scan_en) begin
                clb_chain <= {clb_chain[CLB-2:0], clb_scan_in};
                if (clb_rises < CLB) clb_rec[clb_rises] <= clb_scan_in;
                clb_rises <= clb_rises + 1;
            end
            if (conn_scan_en) begin
                conn_chain <= {conn_chain[CONN-2:0], conn_scan_in};
                if (conn_rises < CONN) conn_rec[conn_rises] <= conn_scan_in;
                conn_rises <= conn_rises + 1;
            end
        end
    end

    // Output event monitor
    int           done_cnt;
    logic [W-1:0] rb_q [$];

    always @(negedge clk or posedge mon_clr) begin
        if (mon_clr) begin
            done_cnt <= 0;
            rb_q.delete();
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (rb_valid) rb_q.push_back(rb_data);
        end
    end

    // SCAN_DIV=1 instance timing monitor
    logic mon1_en = 1'b0;
    logic prev1 = 1'b0;
    int   cyc1 = 0, last1 = -1, rises1 = 0, hi1 = 0, done1_cnt = 0, min1 = 1000, max1 = 0;

    always @(negedge clk) begin
        if (mon1_en) begin
            cyc1 <= cyc1 + 1;
            if (scan_clk1 && !prev1) begin
                rises1 <= rises1 + 1;
                if (last1 >= 0) begin
                    if (cyc1 - last1 < min1) min1 <= cyc1 - last1;
                    if (cyc1 - last1 > max1) max1 <= cyc1 - last1;
                end
                last1 <= cyc1;
            end
            if (scan_clk1) hi1 <= hi1 + 1;
            if (done1) done1_cnt <= done1_cnt + 1;
            prev1 <= scan_clk1;
        end
    end

    int acc_words;

    task automatic clear_mon();
        mon_clr = 1'b1;
        #1;
        mon_clr = 1'b0;
    endtask

    // Offer one load's words; optional 30-cycle stall before stall_idx, start pulse before start_idx
    task automatic run_load(input word_arr_t words, input int stall_idx, input int start_idx, input int max_gap);
        int   gap;
        bit   got;
        bit   stall_ok;
        logic snap_clb_en, snap_conn_en;
        int   snap_rises;
        acc_words = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(NWORDS); i++) begin
            if (i == start_idx) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (i == stall_idx) begin
                got = 0;
                for (int t = 0; t < 200; t++) begin
                    if (cfg_ready) begin got = 1; break; end
                    @(negedge clk);
                end
                check("stall_reach_fetch", 64'(got), 64'd1);
                snap_clb_en  = clb_scan_en;
                snap_conn_en = conn_scan_en;
                snap_rises   = clb_rises + conn_rises;
                stall_ok     = 1;
                for (int c = 0; c < 30; c++) begin
                    if (scan_clk !== 1'b0 || clb_scan_en !== snap_clb_en ||
                        conn_scan_en !== snap_conn_en || cfg_ready !== 1'b1 ||
                        (clb_rises + conn_rises) != snap_rises)
                        stall_ok = 0;
                    @(negedge clk);
                end
                check("stall_hold", 64'(stall_ok), 64'd1);
            end else begin
                gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
                for (int c = 0; c < gap; c++) @(negedge clk);
            end
            cfg_valid = 1'b1;
            cfg_data  = words[i];
            got = 0;
            for (int t = 0; t < 500; t++) begin
                if (cfg_ready) begin
                    @(posedge clk);
                    got = 1;
                    break;
                end
                @(negedge clk);
            end
            @(negedge clk);
            cfg_valid = 1'b0;
            if (!got) return;
            acc_words++;
        end
    endtask

    task automatic wait_done();
        for (int t = 0; t < 3000 && done_cnt == 0; t++) @(negedge clk);
        repeat (10) @(negedge clk);
    endtask

    // Reference: bitstream from words, readback from the pre-load chain contents
    task automatic check_load(input word_arr_t words);
        logic [TOTAL-1:0]    s;
        logic [NWORDS*W-1:0] out;
        logic [CLB-1:0]      exp_clb_chain;
        logic [CONN-1:0]     exp_conn_chain;
        for (int k = 0; k < int'(TOTAL); k++) s[k] = words[k / W][k % W];
        out = '0;
        for (int j = 0; j < int'(CLB); j++) out[j] = clb_pre[CLB-1-j];
        for (int j = 0; j < int'(CONN); j++) out[CLB+j] = conn_pre[CONN-1-j];
        for (int k = 0; k < int'(CLB); k++) exp_clb_chain[CLB-1-k] = s[k];
        for (int k = 0; k < int'(CONN); k++) exp_conn_chain[CONN-1-k] = s[CLB+k];
        check("words_accepted", 64'(acc_words), 64'(NWORDS));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("clb_rises", 64'(clb_rises), 64'(CLB));
        check("conn_rises", 64'(conn_rises), 64'(CONN));
        check("clb_bits", 64'(clb_rec), 64'(s[CLB-1:0]));
        check("conn_bits", 64'(conn_rec), 64'(s[TOTAL-1:CLB]));
        check("clb_chain", 64'(clb_chain), 64'(exp_clb_chain));
        check("conn_chain", 64'(conn_chain), 64'(exp_conn_chain));
        check("rb_count", 64'(rb_q.size()), 64'(NWORDS));
        for (int w = 0; w < int'(NWORDS) && w < rb_q.size(); w++)
            check($sformatf("rb_word%0d", w), 64'(rb_q[w]), 64'(out[w*W +: W]));
    endtask

    word_arr_t words;
    bit        found;

    initial begin
        reset = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        start1 = 1'b0; cfg_valid1 = 1'b0; cfg_data1 = '0;
        clb_pre = '0; conn_pre = '0;
        #1 clear_mon();
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({busy, done, cfg_ready, scan_clk, clb_scan_en, conn_scan_en,
                                    clb_scan_in, conn_scan_in, rb_valid, rb_data}), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Default load: all 0xA5, CLB preloaded with ones, connection chain with zeros
        for (int i = 0; i < int'(NWORDS); i++) words[i] = 8'hA5;
        clb_pre = '1; conn_pre = '0;
        clear_mon();
        run_load(words, -1, -1, 0);
        wait_done();
        check_load(words);
        check("clb_seq_first8", 64'(clb_rec[7:0]), 64'hA5);
        if (rb_q.size() >= 3) begin
            check("rb_fixed_w0", 64'(rb_q[0]), 64'hFF);
            check("rb_fixed_w2", 64'(rb_q[2]), 64'h0F);
        end

        // Random loads: stall before word 4, stray start mid-load, CLB/connection split word
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < int'(NWORDS); i++) words[i] = W'($urandom);
            if (r == 2) words[2] = 8'h0F;
            clb_pre  = CLB'($urandom);
            conn_pre = CONN'({$urandom, $urandom});
            clear_mon();
            run_load(words, (r == 0) ? 3 : -1, (r == 1) ? 5 : -1, 3);
            wait_done();
            check_load(words);
            if (r == 2) begin
                check("split_clb_hi", 64'(clb_rec[19:16]), 64'hF);
                check("split_conn_lo", 64'(conn_rec[3:0]), 64'h0);
            end
        end

        // Asynchronous reset while scan_clk is high
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = W'($urandom);
        found = 0;
        for (int t = 0; t < 200; t++) begin
            if (scan_clk) begin found = 1; break; end
            @(negedge clk);
        end
        check("reach_shift_hi", 64'(found), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_outs", 64'({busy, done, cfg_ready, scan_clk, clb_scan_en, conn_scan_en,
                                       clb_scan_in, conn_scan_in, rb_valid, rb_data}), 64'd0);
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("no_done_on_abort", 64'(done_cnt), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < int'(NWORDS); i++) words[i] = W'($urandom);
        clb_pre  = CLB'($urandom);
        conn_pre = CONN'({$urandom, $urandom});
        clear_mon();
        run_load(words, -1, -1, 1);
        wait_done();
        check_load(words);

        // SCAN_DIV=1 instance: continuous data, measure scan_clk timing
        @(negedge clk);
        mon1_en = 1'b1;
        cfg_valid1 = 1'b1;
        cfg_data1 = 8'h3C;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int t = 0; t < 1000 && done1_cnt == 0; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        cfg_valid1 = 1'b0;
        check("div1_rises", 64'(rises1), 64'(TOTAL));
        check("div1_high_cycles", 64'(hi1), 64'(TOTAL));
        check("div1_min_period", 64'(min1), 64'd2);
        check("div1_max_period", 64'(max1), 64'd3);
        check("div1_done", 64'(done1_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
